// File: rtl/clkgen_multi.sv
// clkgen_multi
//   Multi-channel programmable clock divider. Each channel turns clk into a
//   registered divided clock (clkout) plus a one-cycle tick strobe on every
//   clkout rising edge. Divisor changes and start/stop only take effect on
//   period boundaries, so a channel never emits a truncated pulse.
//
// Ports
//   clk      in   source clock, all logic on its rising edge
//   nrst     in   asynchronous active-low reset
//   en       in   [NCH]       per-channel run request
//   div_wr   in   [NCH]       per-channel divisor write strobe (one cycle)
//   div_in   in   [NCH*DIVW]  divisors, channel i uses [i*DIVW +: DIVW]
//   clkout   out  [NCH]       divided clock, high for (div+1)>>1 cycles
//   tick     out  [NCH]       strobe coincident with each clkout rising edge
//   active   out  [NCH]       channel running
//   pending  out  [NCH]       written divisor not yet applied
module clkgen_multi #(
    parameter int NCH    = 2,
    parameter int DIVW   = 16,
    parameter int DEFDIV = 2
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [NCH-1:0]    en,
    input  logic [NCH-1:0]    div_wr,
    input  logic [NCH*DIVW-1:0] div_in,
    output logic [NCH-1:0]    clkout,
    output logic [NCH-1:0]    tick,
    output logic [NCH-1:0]    active,
    output logic [NCH-1:0]    pending
);

    typedef enum logic {
        CH_IDLE,
        CH_RUN
    } chState_t;

    // Divisors below 2 cannot produce a high and a low phase, so they are
    // promoted to 2 (toggle every cycle).
    localparam logic [DIVW-1:0] RESET_DIV = (DEFDIV < 2) ? DIVW'(2) : DIVW'(DEFDIV);

    function automatic logic [DIVW-1:0] clampDiv(input logic [DIVW-1:0] v);
        return (v < DIVW'(2)) ? DIVW'(2) : v;
    endfunction

    for (genvar i = 0; i < NCH; i++) begin : gCh

        chState_t          state_q, state_d;
        logic [DIVW-1:0]   div_q, div_d;
        logic [DIVW-1:0]   cnt_q, cnt_d;
        logic [DIVW-1:0]   pendDiv_q, pendDiv_d;
        logic              clkOut_q, clkOut_d;
        logic              tick_q, tick_d;
        logic              pend_q, pend_d;

        logic [DIVW-1:0]   wrDiv;
        logic [DIVW-1:0]   applyDiv;
        logic              boundary;
        logic [DIVW:0]     hiCnt;
        logic [DIVW:0]     cntNext;

        assign wrDiv    = clampDiv(div_in[i*DIVW +: DIVW]);
        assign boundary = (cnt_q == div_q - DIVW'(1));
        // One extra bit so (div+1) and (cnt+1) cannot wrap at the top of range.
        assign hiCnt    = ({1'b0, div_q} + (DIVW+1)'(1)) >> 1;
        assign cntNext  = {1'b0, cnt_q} + (DIVW+1)'(1);
        // A same-cycle write wins over an older pending value.
        assign applyDiv = div_wr[i] ? wrDiv : (pend_q ? pendDiv_q : div_q);

        always_comb begin
            state_d   = state_q;
            div_d     = div_q;
            cnt_d     = cnt_q;
            pendDiv_d = pendDiv_q;
            clkOut_d  = clkOut_q;
            tick_d    = 1'b0;
            pend_d    = pend_q;

            if (div_wr[i]) begin
                pendDiv_d = wrDiv;
            end

            case (state_q)
                CH_IDLE: begin
                    clkOut_d = 1'b0;
                    if (en[i]) begin
                        // Start edge behaves as a boundary wrap with any new divisor.
                        state_d  = CH_RUN;
                        div_d    = applyDiv;
                        pend_d   = 1'b0;
                        cnt_d    = '0;
                        clkOut_d = 1'b1;
                        tick_d   = 1'b1;
                    end else if (pend_q) begin
                        // Idle channels take a written divisor one edge later;
                        // a write arriving now becomes the next pending value.
                        div_d  = pendDiv_q;
                        cnt_d  = pendDiv_q - DIVW'(1);
                        pend_d = div_wr[i];
                    end else if (div_wr[i]) begin
                        pend_d = 1'b1;
                    end
                end

                CH_RUN: begin
                    if (boundary) begin
                        div_d  = applyDiv;
                        pend_d = 1'b0;
                        if (en[i]) begin
                            cnt_d    = '0;
                            clkOut_d = 1'b1;
                            tick_d   = 1'b1;
                        end else begin
                            // Stop only here so the last period is always complete.
                            state_d  = CH_IDLE;
                            cnt_d    = applyDiv - DIVW'(1);
                            clkOut_d = 1'b0;
                        end
                    end else begin
                        cnt_d    = cnt_q + DIVW'(1);
                        clkOut_d = (cntNext < hiCnt);
                        if (div_wr[i]) begin
                            pend_d = 1'b1;
                        end
                    end
                end

                default: begin
                    state_d = CH_IDLE;
                end
            endcase
        end

        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                state_q   <= CH_IDLE;
                div_q     <= RESET_DIV;
                cnt_q     <= RESET_DIV - DIVW'(1);
                pendDiv_q <= '0;
                clkOut_q  <= 1'b0;
                tick_q    <= 1'b0;
                pend_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                div_q     <= div_d;
                cnt_q     <= cnt_d;
                pendDiv_q <= pendDiv_d;
                clkOut_q  <= clkOut_d;
                tick_q    <= tick_d;
                pend_q    <= pend_d;
            end
        end

        assign clkout[i]  = clkOut_q;
        assign tick[i]    = tick_q;
        assign active[i]  = (state_q == CH_RUN);
        assign pending[i] = pend_q;
    end

endmodule

// File: tb/tb_clkgen_multi.sv
// tb_clkgen_multi
//   Scoreboard bench for clkgen_multi (NCH=2, DIVW=16). Stimulus pushes the
//   hand-derived output state expected after each clock edge; a monitor pops
//   and compares after each edge (or after an asynchronous reset event).
module tb_clkgen_multi;

    logic        clk;
    logic        nrst;
    logic [1:0]  en;
    logic [1:0]  div_wr;
    logic [31:0] div_in;
    logic [1:0]  clkout;
    logic [1:0]  tick;
    logic [1:0]  active;
    logic [1:0]  pending;

    typedef struct {
        string      name;
        logic [7:0] val;
    } exp_t;

    exp_t expQ[$];
    event sampleEv;
    int   errors = 0;
    int   checks = 0;
    bit   tickWin = 0;
    int   tickCnt0 = 0;
    int   tickCnt1 = 0;

    clkgen_multi #(
        .NCH(2),
        .DIVW(16),
        .DEFDIV(2)
    ) dut (
        .clk    (clk),
        .nrst   (nrst),
        .en     (en),
        .div_wr (div_wr),
        .div_in (div_in),
        .clkout (clkout),
        .tick   (tick),
        .active (active),
        .pending(pending)
    );

    // Free-running source clock: rising edges at 5,15,25..., falling at 10,20...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backstop so the run always ends even if stimulus gets stuck.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout want normal completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison; packed values are {pending, active, tick, clkout}.
    task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %b (%0d) want %b (%0d)", name, got, got, want, want);
        end
    endtask

    // Monitor: after every rising edge (or a forced sample during reset) it
    // pops the next expected state and compares, and counts ticks in a window.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or sampleEv);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e.name, {pending, active, tick, clkout}, e.val);
            end
            if (tickWin) begin
                tickCnt0 += int'(tick[0]);
                tickCnt1 += int'(tick[1]);
            end
        end
    end

    // Drive one cycle of inputs at a falling edge and queue the state expected
    // after the following rising edge.
    task automatic applyStimulus(input string name, input logic [1:0] enV, input logic [1:0] wrV,
                                 input logic [15:0] d0, input logic [15:0] d1,
                                 input logic [1:0] eClk, input logic [1:0] eTick,
                                 input logic [1:0] eAct, input logic [1:0] ePend);
        exp_t e;
        en     = enV;
        div_wr = wrV;
        div_in = {d1, d0};
        e.name = name;
        e.val  = {ePend, eAct, eTick, eClk};
        expQ.push_back(e);
        @(negedge clk);
    endtask

    // Channel-0 vector run; each string character is one cycle, channel 1 idle.
    task automatic runPattern(input string name, input string enS, input string wrS,
                              input logic [15:0] divV, input string clkS, input string tickS,
                              input string actS, input string pendS);
        for (int k = 0; k < clkS.len(); k++) begin
            applyStimulus(name, {1'b0, enS[k] == "1"}, {1'b0, wrS[k] == "1"}, divV, 16'd0,
                          {1'b0, clkS[k] == "1"}, {1'b0, tickS[k] == "1"},
                          {1'b0, actS[k] == "1"}, {1'b0, pendS[k] == "1"});
        end
    endtask

    // Directed test sequence.
    initial begin
        exp_t       e;
        int         c0;
        int         c1;
        logic [1:0] w;

        nrst   = 1'b0;
        en     = 2'b00;
        div_wr = 2'b00;
        div_in = '0;
        repeat (2) @(negedge clk);
        e.name = "T1 reset values";
        e.val  = 8'h00;
        expQ.push_back(e);
        ->sampleEv;
        @(negedge clk);
        nrst = 1'b1;

        runPattern("T1 idle after reset", "00", "00", 16'd0, "00", "00", "00", "00");
        runPattern("T1 default div2", "1111", "0000", 16'd0, "1010", "1010", "1111", "0000");
        runPattern("T1 stop div2", "0", "0", 16'd0, "0", "0", "0", "0");

        runPattern("T2 idle write", "0", "1", 16'd4, "0", "0", "0", "1");
        runPattern("T2 div4", "11111111", "00000000", 16'd0,
                   "11001100", "10001000", "11111111", "00000000");

        runPattern("T3 div5 at boundary", "1111111111", "1000000000", 16'd5,
                   "1110011100", "1000010000", "1111111111", "0000000000");
        runPattern("T3 clamp div0", "1111", "1000", 16'd0, "1010", "1010", "1111", "0000");
        runPattern("T3 clamp div1", "1111", "1000", 16'd1, "1010", "1010", "1111", "0000");

        runPattern("T4 div8", "111", "100", 16'd8, "111", "100", "111", "000");
        runPattern("T4 write3 midperiod", "11111111111", "10000000000", 16'd3,
                   "10000110110", "00000100100", "11111111111", "11111000000");

        runPattern("T5 stop div6", "1100000", "1000000", 16'd6,
                   "1110000", "1000000", "1111110", "0000000");
        runPattern("T5 restart and cancel", "01101111000000", "00000000000000", 16'd0,
                   "01110001110000", "01000001000000", "01111111111110", "00000000000000");

        // Both channels start together with new divisors 2 and 7 (hi=4).
        tickWin = 1'b1;
        for (int k = 1; k <= 44; k++) begin
            c0 = (k - 1) % 2;
            c1 = (k - 1) % 7;
            w  = (k == 1) ? 2'b11 : ((k == 44) ? 2'b10 : 2'b00);
            applyStimulus("T6 independence", 2'b11, w,
                          (k == 1) ? 16'd2 : 16'd0, (k == 1) ? 16'd7 : 16'd3,
                          {c1 < 4, c0 == 0}, {c1 == 0, c0 == 0}, 2'b11, {k == 44, 1'b0});
            if (k == 42) tickWin = 1'b0;
        end

        // Asynchronous reset mid-run with a write pending on channel 1.
        nrst   = 1'b0;
        en     = 2'b00;
        div_wr = 2'b00;
        e.name = "T1 async reset drop";
        e.val  = 8'h00;
        expQ.push_back(e);
        ->sampleEv;
        applyStimulus("T1 held in reset", 2'b00, 2'b00, 16'd0, 16'd0, 2'b00, 2'b00, 2'b00, 2'b00);
        applyStimulus("T1 held in reset", 2'b00, 2'b00, 16'd0, 16'd0, 2'b00, 2'b00, 2'b00, 2'b00);
        nrst = 1'b1;
        applyStimulus("T1 idle after release", 2'b00, 2'b00, 16'd0, 16'd0, 2'b00, 2'b00, 2'b00, 2'b00);
        applyStimulus("T1 ch1 restart div2", 2'b10, 2'b00, 16'd0, 16'd0, 2'b10, 2'b10, 2'b10, 2'b00);
        applyStimulus("T1 ch1 restart div2", 2'b10, 2'b00, 16'd0, 16'd0, 2'b00, 2'b00, 2'b10, 2'b00);
        applyStimulus("T1 ch1 restart div2", 2'b10, 2'b00, 16'd0, 16'd0, 2'b10, 2'b10, 2'b10, 2'b00);
        applyStimulus("T1 ch1 restart div2", 2'b10, 2'b00, 16'd0, 16'd0, 2'b00, 2'b00, 2'b10, 2'b00);

        en = 2'b00;
        repeat (3) @(negedge clk);
        checkOutput("scoreboard drained", 8'(expQ.size()), 8'd0);
        checkOutput("T6 ch0 tick count", 8'(tickCnt0), 8'd21);
        checkOutput("T6 ch1 tick count", 8'(tickCnt1), 8'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
